// File: rtl/mat_mul_seq_pkg.sv
// Shared definitions for the sequential matrix multiplier: FSM states and
// the row-major, MSB-first element offset helper used to unpack a, b and c.
package mat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // LSB position of element [row][col] in a packed matrix whose [0][0] sits in the MSBs.
    function automatic int elem_off(input int row, input int col,
                                    input int rows, input int cols, input int w);
        return ((rows * cols - 1) - (row * cols + col)) * w;
    endfunction

endpackage

// File: rtl/mat_mul_seq_mac_lane.sv
// One multiply-accumulate lane: extends two W-bit operands to OUT_W and adds
// their product into an OUT_W accumulator, wrapping modulo 2^OUT_W.
module mac_lane #(
    parameter int W      = 15,
    parameter int OUT_W  = 15,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [W-1:0]     a_op,
    input  logic [W-1:0]     b_op,
    output logic [OUT_W-1:0] acc
);

    logic [OUT_W-1:0] a_ext_s;
    logic [OUT_W-1:0] b_ext_s;
    logic [OUT_W-1:0] prod_s;
    logic [OUT_W-1:0] acc_r;

    if (SIGNED != 0) begin : g_sext
        assign a_ext_s = OUT_W'($signed(a_op));
        assign b_ext_s = OUT_W'($signed(b_op));
    end else begin : g_zext
        assign a_ext_s = OUT_W'(a_op);
        assign b_ext_s = OUT_W'(b_op);
    end

    // Truncated product: only the low OUT_W bits ever matter for a wrapping sum.
    assign prod_s = a_ext_s * b_ext_s;
    assign acc    = acc_r;

    // Accumulator register with clear taking priority over accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {OUT_W{1'b0}};
        end else if (clr) begin
            acc_r <= {OUT_W{1'b0}};
        end else if (en) begin
            acc_r <= acc_r + prod_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/mat_mul_seq.sv
// Sequential matrix multiplier C = A x B using M*N MAC lanes, one k-step per
// cycle, with valid/ready handshakes on both sides and fully registered outputs.
module mat_mul_seq
    import mat_pkg::*;
#(
    parameter int M      = 5,
    parameter int K      = 2,
    parameter int N      = 3,
    parameter int W      = 15,
    parameter int OUT_W  = 15,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M*K*W-1:0]     a,
    input  logic [K*N*W-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [M*N*OUT_W-1:0] c,
    output logic                 busy
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [KW-1:0]    k_r;
    logic [M*K*W-1:0] a_r;
    logic [K*N*W-1:0] b_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             capture_s;
    logic             k_last_s;
    logic             acc_en_s;

    assign capture_s = (state_r == IDLE) && in_valid;
    assign k_last_s  = (k_r == KW'(K - 1));
    assign acc_en_s  = (state_r == ACC);

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_nxt_s = ACC;
                else          state_nxt_s = IDLE;
            end
            ACC: begin
                if (k_last_s) state_nxt_s = DONE;
                else          state_nxt_s = ACC;
            end
            DONE: begin
                if (out_ready) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, k counter and status flags; flags are decoded from the next state so they are flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            k_r         <= {KW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s == ACC) || (state_nxt_s == DONE);
            if (capture_s) begin
                k_r <= {KW{1'b0}};
            end else if (acc_en_s && !k_last_s) begin
                k_r <= k_r + KW'(1);
            end else begin
                k_r <= k_r;
            end
        end
    end

    // Operand capture; the source is free to change a/b after the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= {(M*K*W){1'b0}};
            b_r <= {(K*N*W){1'b0}};
        end else if (capture_s) begin
            a_r <= a;
            b_r <= b;
        end else begin
            a_r <= a_r;
            b_r <= b_r;
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [W-1:0]     a_op_s;
            logic [W-1:0]     b_op_s;
            logic [OUT_W-1:0] acc_s;

            assign a_op_s = a_r[elem_off(i, int'(k_r), M, K, W) +: W];
            assign b_op_s = b_r[elem_off(int'(k_r), j, K, N, W) +: W];

            mac_lane #(
                .W      (W),
                .OUT_W  (OUT_W),
                .SIGNED (SIGNED)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .clr  (capture_s),
                .en   (acc_en_s),
                .a_op (a_op_s),
                .b_op (b_op_s),
                .acc  (acc_s)
            );

            assign c[elem_off(i, j, M, N, OUT_W) +: OUT_W] = acc_s;
        end
    end

endmodule

// File: tb/tb_mat_mul_seq.sv
// Directed self-checking bench for mat_mul_seq: default, wrap, back-pressure,
// mid-operation reset, signed/unsigned extension and K=1 throughput.
module tb_mat_mul_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default instance (M=5, K=2, N=3, W=15, OUT_W=15)
    logic           in_valid_d, out_ready_d;
    logic [149:0]   a_d;
    logic [89:0]    b_d;
    logic           in_ready_d, out_valid_d, busy_d;
    logic [224:0]   c_d;

    // Signed / unsigned 32-bit-output instances sharing a_d/b_d
    logic           in_valid_s, out_ready_s;
    logic           in_ready_s0, out_valid_s0, busy_s0;
    logic           in_ready_s1, out_valid_s1, busy_s1;
    logic [479:0]   c_s0, c_s1;

    // K=1, M=N=2 instance
    logic           in_valid_k, out_ready_k;
    logic [29:0]    a_k, b_k;
    logic           in_ready_k, out_valid_k, busy_k;
    logic [59:0]    c_k;

    mat_mul_seq u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid_d), .in_ready(in_ready_d),
        .a(a_d), .b(b_d), .out_valid(out_valid_d), .out_ready(out_ready_d),
        .c(c_d), .busy(busy_d)
    );

    mat_mul_seq #(.OUT_W(32), .SIGNED(0)) u_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s0),
        .a(a_d), .b(b_d), .out_valid(out_valid_s0), .out_ready(out_ready_s),
        .c(c_s0), .busy(busy_s0)
    );

    mat_mul_seq #(.OUT_W(32), .SIGNED(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s1),
        .a(a_d), .b(b_d), .out_valid(out_valid_s1), .out_ready(out_ready_s),
        .c(c_s1), .busy(busy_s1)
    );

    mat_mul_seq #(.M(2), .K(1), .N(2)) u_k (
        .clk(clk), .rst(rst), .in_valid(in_valid_k), .in_ready(in_ready_k),
        .a(a_k), .b(b_k), .out_valid(out_valid_k), .out_ready(out_ready_k),
        .c(c_k), .busy(busy_k)
    );

    longint am [5][2];
    longint bm [2][3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_el(input logic [2047:0] v, input int r, input int col,
                                           input int rows, input int cols, input int w);
        logic [2047:0] t;
        t = v >> (((rows * cols - 1) - (r * cols + col)) * w);
        return t[63:0] & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [2047:0] put_el(input logic [2047:0] v, input int r, input int col,
                                             input int rows, input int cols, input int w,
                                             input logic [63:0] val);
        logic [2047:0] mask;
        int            off;
        off  = ((rows * cols - 1) - (r * cols + col)) * w;
        mask = {1984'd0, ((64'd1 << w) - 64'd1)};
        return (v & ~(mask << off)) | ((2048'(val) & mask) << off);
    endfunction

    task automatic load_d();
        logic [2047:0] va, vb;
        va = '0;
        vb = '0;
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 2; k++) va = put_el(va, i, k, 5, 2, 15, 64'(am[i][k]));
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 3; j++) vb = put_el(vb, k, j, 2, 3, 15, 64'(bm[k][j]));
        a_d = va[149:0];
        b_d = vb[89:0];
    endtask

    task automatic check_c_d(input string tag);
        logic [2047:0] e;
        longint        s;
        e = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++) s += am[i][k] * bm[k][j];
                e = put_el(e, i, j, 5, 3, 15, 64'(s));
            end
        chk(tag, 256'(c_d), e[255:0]);
    endtask

    task automatic clear_mats();
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 2; k++) am[i][k] = 0;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 3; j++) bm[k][j] = 0;
    endtask

    initial begin
        int lat;
        int last_acc;
        rst = 1'b1;
        in_valid_d = 1'b0; out_ready_d = 1'b0; a_d = '0; b_d = '0;
        in_valid_s = 1'b0; out_ready_s = 1'b0;
        in_valid_k = 1'b0; out_ready_k = 1'b0; a_k = '0; b_k = '0;
        step();
        step();
        chk("rst_in_ready", 256'(in_ready_d), 256'(1));
        chk("rst_out_valid", 256'(out_valid_d), 256'(0));
        chk("rst_busy", 256'(busy_d), 256'(0));
        chk("rst_c", 256'(c_d), 256'(0));
        rst = 1'b0;

        // Default pattern: A rows [i+1, 2], B = [1,2,3; 4,5,6]
        for (int i = 0; i < 5; i++) begin am[i][0] = i + 1; am[i][1] = 2; end
        bm[0][0] = 1; bm[0][1] = 2; bm[0][2] = 3;
        bm[1][0] = 4; bm[1][1] = 5; bm[1][2] = 6;
        load_d();
        in_valid_d = 1'b1;
        step();
        in_valid_d = 1'b0;
        a_d = {150{1'b1}};
        b_d = {90{1'b1}};
        chk("acc_busy", 256'(busy_d), 256'(1));
        chk("acc_in_ready", 256'(in_ready_d), 256'(0));
        chk("acc_out_valid_c1", 256'(out_valid_d), 256'(0));
        step();
        chk("acc_out_valid_c2", 256'(out_valid_d), 256'(0));
        step();
        chk("done_out_valid", 256'(out_valid_d), 256'(1));
        check_c_d("default_c");
        chk("default_c00", 256'(get_el(2048'(c_d), 0, 0, 5, 3, 15)), 256'(9));
        chk("default_c01", 256'(get_el(2048'(c_d), 0, 1, 5, 3, 15)), 256'(12));
        chk("default_c02", 256'(get_el(2048'(c_d), 0, 2, 5, 3, 15)), 256'(15));
        chk("default_c40", 256'(get_el(2048'(c_d), 4, 0, 5, 3, 15)), 256'(13));
        chk("default_c41", 256'(get_el(2048'(c_d), 4, 1, 5, 3, 15)), 256'(20));
        chk("default_c42", 256'(get_el(2048'(c_d), 4, 2, 5, 3, 15)), 256'(27));

        // Back-pressure: five cycles held in DONE, with an in_valid pulse that must be ignored
        for (int n = 0; n < 5; n++) begin
            in_valid_d = (n == 2) ? 1'b1 : 1'b0;
            step();
            chk("bp_out_valid", 256'(out_valid_d), 256'(1));
            chk("bp_in_ready", 256'(in_ready_d), 256'(0));
            check_c_d("bp_c_stable");
        end
        in_valid_d  = 1'b0;
        out_ready_d = 1'b1;
        step();
        out_ready_d = 1'b0;
        chk("release_in_ready", 256'(in_ready_d), 256'(1));
        chk("release_out_valid", 256'(out_valid_d), 256'(0));
        chk("release_busy", 256'(busy_d), 256'(0));
        check_c_d("release_c_held");

        // Wrap, with out_ready held high through ACC (must be ignored there)
        clear_mats();
        am[0][0] = 64'h7FFF;
        bm[0][0] = 2;
        load_d();
        out_ready_d = 1'b1;
        in_valid_d  = 1'b1;
        step();
        in_valid_d = 1'b0;
        lat = 0;
        while (out_valid_d !== 1'b1 && lat < 20) begin step(); lat++; end
        chk("wrap_latency", 256'(lat), 256'(2));
        chk("wrap_c00", 256'(get_el(2048'(c_d), 0, 0, 5, 3, 15)), 256'(16'h7FFE));
        check_c_d("wrap_c");
        step();
        out_ready_d = 1'b0;
        chk("wrap_back_idle", 256'(in_ready_d), 256'(1));

        // Reset during the first ACC cycle
        clear_mats();
        for (int i = 0; i < 5; i++) begin am[i][0] = i + 1; am[i][1] = 2; end
        bm[0][0] = 1; bm[0][1] = 2; bm[0][2] = 3;
        bm[1][0] = 4; bm[1][1] = 5; bm[1][2] = 6;
        load_d();
        in_valid_d = 1'b1;
        step();
        in_valid_d = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", 256'(in_ready_d), 256'(1));
        chk("midrst_out_valid", 256'(out_valid_d), 256'(0));
        chk("midrst_busy", 256'(busy_d), 256'(0));
        chk("midrst_c", 256'(c_d), 256'(0));
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 2; k++) am[i][k] = i * 3 + k + 7;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 3; j++) bm[k][j] = k * 5 + j + 100;
        load_d();
        in_valid_d = 1'b1;
        step();
        in_valid_d = 1'b0;
        step();
        step();
        chk("after_rst_out_valid", 256'(out_valid_d), 256'(1));
        check_c_d("after_rst_c");
        out_ready_d = 1'b1;
        step();
        out_ready_d = 1'b0;

        // Signed vs unsigned extension into 32-bit outputs
        clear_mats();
        am[0][0] = 64'h7FFF;
        bm[0][0] = 3;
        load_d();
        in_valid_s = 1'b1;
        step();
        in_valid_s = 1'b0;
        lat = 0;
        while (out_valid_s1 !== 1'b1 && lat < 20) begin step(); lat++; end
        chk("signed_latency", 256'(lat), 256'(2));
        chk("unsigned_out_valid", 256'(out_valid_s0), 256'(1));
        chk("signed_c00", 256'(get_el(2048'(c_s1), 0, 0, 5, 3, 32)), 256'(32'hFFFF_FFFD));
        chk("unsigned_c00", 256'(get_el(2048'(c_s0), 0, 0, 5, 3, 32)), 256'(32'h0001_7FFD));
        chk("signed_c42", 256'(get_el(2048'(c_s1), 4, 2, 5, 3, 32)), 256'(0));
        out_ready_s = 1'b1;
        step();
        out_ready_s = 1'b0;
        chk("signed_back_idle", 256'(in_ready_s1), 256'(1));

        // K=1, M=N=2: A=[3;4], B=[5,6]
        a_k = {15'd3, 15'd4};
        b_k = {15'd5, 15'd6};
        in_valid_k  = 1'b1;
        out_ready_k = 1'b1;
        step();
        chk("k1_acc_out_valid", 256'(out_valid_k), 256'(0));
        chk("k1_acc_busy", 256'(busy_k), 256'(1));
        step();
        chk("k1_out_valid", 256'(out_valid_k), 256'(1));
        chk("k1_c", 256'(c_k), 256'({15'd15, 15'd18, 15'd20, 15'd24}));
        last_acc = -1;
        for (int n = 0; n < 10; n++) begin
            step();
            if (in_ready_k === 1'b1) begin
                if (last_acc >= 0) chk("k1_accept_spacing", 256'(n - last_acc), 256'(3));
                last_acc = n;
            end
        end
        chk("k1_accept_seen", 256'(last_acc >= 0), 256'(1));
        in_valid_k = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mat_mul_seq.md
Name: mat_mul_seq

Overview:
- Parametrised sequential matrix multiplier: C[M][N] = A[M][K] x B[K][N].
- Successor of the fixed 5x2 x 2x3, 15-bit pipelined multiplier: generalised dimensions, element width and output width, with an optional signed mode.
- Adds a valid/ready handshake on input and output, plus back-pressure.
- Sits between the matrix loader and the result sink in the MultMatriz datapath.
- Uses M*N parallel MAC lanes and iterates over the K dimension, one k-step per cycle.

Parameters:
- M, 5, rows of A and C (>=1)
- K, 2, columns of A / rows of B; number of accumulate cycles (>=1)
- N, 3, columns of B and C (>=1)
- W, 15, input element width in bits
- OUT_W, 15, output element width in bits (>=W)
- SIGNED, 0, 1: operands sign-extended to OUT_W; 0: zero-extended

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  a/b hold a valid matrix pair
- in_ready  out  1  block can accept a pair; high only in IDLE
- a  in  M*K*W  A packed row-major; A[0][0] in MSBs, A[M-1][K-1] in LSBs
- b  in  K*N*W  B packed row-major; B[0][0] in MSBs
- out_valid  out  1  c holds a completed product
- out_ready  in  1  sink accepts c
- c  out  M*N*OUT_W  C packed row-major; C[0][0] in MSBs
- busy  out  1  high in ACC or DONE

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high. With rst=1 at an edge the block forces:
  - state to IDLE
  - k counter to 0
  - all accumulators, and therefore c, to 0
  - out_valid to 0 and busy to 0
  - in_ready=1 from the following cycle
  - rst overrides every other input.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: capture a and b into internal registers, clear all accumulators, set k=0, go to ACC.
  - The a/b inputs are don't-care after the capture edge.
- ACC (one edge per k, k = 0..K-1):
  - For every i,j: acc[i][j] <= acc[i][j] + ext(A[i][k]) * ext(B[k][j]).
  - ext is sign- or zero-extension from W to OUT_W, selected by SIGNED.
  - Products and sums are taken modulo 2^OUT_W; overflow wraps silently and no saturation is applied.
  - On the edge with k==K-1, go to DONE; otherwise increment k.
- DONE:
  - out_valid=1; c equals the accumulators and is held stable.
  - On out_ready=1: go to IDLE and drop out_valid.
  - c keeps its last value until the next capture clears it.
- Latency: out_valid rises exactly K cycles after the accept edge. With out_ready held high, throughput is one pair per K+2 cycles.
- Boundary cases:
  - K=1: ACC lasts a single cycle; the k counter is sized max(1, $clog2(K)).
  - out_ready asserted outside DONE is ignored.
  - in_valid asserted outside IDLE is ignored; no capture occurs and the source must hold its data.
  - rst asserted during ACC or DONE abandons the operation; the result is never presented.
- c is a pure register output: no combinational path from any input to c, in_ready or out_valid.

Decomposition:
- Shared package mat_pkg:
  - state enum (IDLE, ACC, DONE)
  - helper function for element index / packed-slice offset, used for row-major MSB-first unpacking of a, b and c
- Sub-module mac_lane:
  - one OUT_W accumulator with clear, enable, and a multiply-add of two extended W-bit operands
  - instantiated M*N times in a generate loop
- Top level: FSM, k counter, operand registers and the packing logic.

Test Plan:
- Defaults (M=5, K=2, N=3, W=15): A rows [i+1, 2], B rows [1,2,3] / [4,5,6] -> C row0 = [9,12,15], row4 = [13,20,27]; out_valid exactly 2 cycles after accept.
- Wrap: A[0][0]=0x7FFF, B[0][0]=2, all other elements 0 -> C[0][0]=0x7FFE, every other C element 0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> c stable, out_valid=1, in_ready=0, and a pulsed in_valid is ignored; then out_ready=1 -> IDLE next cycle with in_ready=1.
- Reset mid-op: assert rst in the first ACC cycle -> next cycle state IDLE, c all zero, out_valid=0; a following pair computes correctly.
- Signed mode (SIGNED=1, OUT_W=32): A[0][0]=0x7FFF (-1), B[0][0]=3 -> C[0][0]=0xFFFFFFFD. The same stimulus with SIGNED=0 -> 0x00017FFD.
- K=1, M=N=2: A=[3;4], B=[5,6] -> C=[15,18;20,24]; out_valid 1 cycle after accept; back-to-back pairs with out_ready tied high are accepted every 3 cycles.
